// File: rtl/vga_seg_display_if.sv
// rtl/vga_seg_display_if.sv - pixel/segment bus between VGA timing logic and the seven-segment overlay
interface vga_seg_display_if #(
    parameter int NUM_DIGITS = 6
);
    logic [9:0]              x;
    logic [9:0]              y;
    logic                    frame_start;
    logic [7*NUM_DIGITS-1:0] seg_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_en;
    logic                    in_digit;
    logic [23:0]             digit_color;

    modport master (
        output x, y, frame_start, seg_in, blink_mask, lz_en,
        input  in_digit, digit_color
    );

    modport slave (
        input  x, y, frame_start, seg_in, blink_mask, lz_en,
        output in_digit, digit_color
    );
endinterface

// File: rtl/vga_seg_display.sv
// rtl/vga_seg_display.sv - two-stage pipelined seven-segment VGA overlay with frame-synchronous shadow, blink and leading-zero blanking
module vga_seg_display #(
    parameter int          NUM_DIGITS    = 6,
    parameter logic [9:0]  BASE_X        = 10'd10,
    parameter logic [9:0]  BASE_Y        = 10'd405,
    parameter logic [9:0]  DIGIT_WIDTH   = 10'd30,
    parameter logic [9:0]  DIGIT_HEIGHT  = 10'd40,
    parameter logic [9:0]  DIGIT_SPACING = 10'd35,
    parameter logic [9:0]  SEG_THICK     = 10'd4,
    parameter logic [23:0] ON_COLOR      = 24'h000000,
    parameter logic [23:0] OFF_COLOR     = 24'h006080,
    parameter logic [23:0] BG_COLOR      = 24'h006080,
    parameter int          BLINK_FRAMES  = 30
) (
    input  logic               clk,
    input  logic               resetn,
    vga_seg_display_if.slave   bus
);

    localparam int          CW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [10:0] Y_END    = {1'b0, BASE_Y} + {1'b0, DIGIT_HEIGHT};
    localparam logic [9:0]  H2       = DIGIT_HEIGHT >> 1;
    localparam logic [9:0]  T2       = SEG_THICK >> 1;
    localparam logic [9:0]  W_MT     = DIGIT_WIDTH - SEG_THICK;
    localparam logic [9:0]  H_MT     = DIGIT_HEIGHT - SEG_THICK;
    localparam logic [9:0]  G_LO     = H2 - T2;
    localparam logic [9:0]  G_HI     = H2 + T2;

    // Left edge of digit i; digit NUM_DIGITS-1 sits at BASE_X.
    function automatic logic [9:0] cell_x(input int i);
        return BASE_X + 10'(NUM_DIGITS - 1 - i) * DIGIT_SPACING;
    endfunction

    logic [7*NUM_DIGITS-1:0] shadow_seg_q;
    logic [NUM_DIGITS-1:0]   shadow_blink_q;
    logic [NUM_DIGITS-1:0]   shadow_blank_q;
    logic [NUM_DIGITS-1:0]   lz_mask_d;
    logic                    lz_run;
    logic [CW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;

    logic                    y_in;
    logic                    hit_d, hit_q;
    logic [9:0]              rel_x_d, rel_x_q;
    logic [9:0]              rel_y_d, rel_y_q;
    logic [6:0]              pat_d, pat_q;
    logic                    sup_d, sup_q;
    logic                    v1_q;

    logic [6:0]              region;
    logic                    lit;
    logic                    in_digit_d, in_digit_q;
    logic [23:0]             digit_color_d, digit_color_q;

    // A digit is a leading zero only if every digit to its left is also "0".
    always_comb begin
        lz_mask_d = '0;
        lz_run    = bus.lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run       = lz_run & (bus.seg_in[7*i +: 7] == 7'h40);
            lz_mask_d[i] = lz_run;
        end
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        if (bus.frame_start) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shadow_seg_q   <= '1;
            shadow_blink_q <= '0;
            shadow_blank_q <= '0;
            frame_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (bus.frame_start) begin
                shadow_seg_q   <= bus.seg_in;
                shadow_blink_q <= bus.blink_mask;
                shadow_blank_q <= lz_mask_d;
            end
        end
    end

    assign y_in = ({1'b0, bus.y} >= {1'b0, BASE_Y}) && ({1'b0, bus.y} < Y_END);

    // Cells never overlap, so the first match is the only match.
    always_comb begin
        hit_d   = 1'b0;
        rel_x_d = '0;
        rel_y_d = bus.y - BASE_Y;
        pat_d   = '1;
        sup_d   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!hit_d && y_in && (bus.x >= cell_x(i)) &&
                ({1'b0, bus.x} < {1'b0, cell_x(i)} + {1'b0, DIGIT_WIDTH})) begin
                hit_d   = 1'b1;
                rel_x_d = bus.x - cell_x(i);
                pat_d   = shadow_seg_q[7*i +: 7];
                sup_d   = (blink_phase_q & shadow_blink_q[i]) | shadow_blank_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q    <= 1'b0;
            hit_q   <= 1'b0;
            rel_x_q <= '0;
            rel_y_q <= '0;
            pat_q   <= '1;
            sup_q   <= 1'b0;
        end else begin
            v1_q    <= 1'b1;
            hit_q   <= hit_d;
            rel_x_q <= rel_x_d;
            rel_y_q <= rel_y_d;
            pat_q   <= pat_d;
            sup_q   <= sup_d;
        end
    end

    always_comb begin
        region[0] = (rel_y_q < SEG_THICK) && (rel_x_q >= SEG_THICK) && (rel_x_q < W_MT);
        region[1] = (rel_y_q >= SEG_THICK) && (rel_y_q < H2) && (rel_x_q >= W_MT);
        region[2] = (rel_y_q >= H2) && (rel_y_q < H_MT) && (rel_x_q >= W_MT);
        region[3] = (rel_y_q >= H_MT) && (rel_x_q >= SEG_THICK) && (rel_x_q < W_MT);
        region[4] = (rel_y_q >= H2) && (rel_y_q < H_MT) && (rel_x_q < SEG_THICK);
        region[5] = (rel_y_q >= SEG_THICK) && (rel_y_q < H2) && (rel_x_q < SEG_THICK);
        region[6] = (rel_y_q >= G_LO) && (rel_y_q < G_HI) &&
                    (rel_x_q >= SEG_THICK) && (rel_x_q < W_MT);
        lit       = !sup_q && (|(region & ~pat_q));

        in_digit_d    = v1_q && hit_q;
        digit_color_d = BG_COLOR;
        if (in_digit_d) begin
            if (lit) begin
                digit_color_d = ON_COLOR;
            end else if (|region) begin
                digit_color_d = OFF_COLOR;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_digit_q    <= 1'b0;
            digit_color_q <= BG_COLOR;
        end else begin
            in_digit_q    <= in_digit_d;
            digit_color_q <= digit_color_d;
        end
    end

    assign bus.in_digit    = in_digit_q;
    assign bus.digit_color = digit_color_q;

endmodule
